// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFront,
        StShift,
        StBack,
        StHold
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
    localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
    localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
    localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK divider: free-running counter while enabled. It produces a tick at every
// half-period boundary, and splits ticks into leading/trailing edge strobes by the counter MSB.
module spi_sclk_div #(
    parameter int unsigned DIV_LOG2 = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o,
    output logic lead_o,
    output logic trail_o
);

    localparam logic [DIV_LOG2-2:0] HalfMax = '1;

    logic [DIV_LOG2-1:0] cnt_q, cnt_d;

    assign tick_o  = en_i && (cnt_q[DIV_LOG2-2:0] == HalfMax);
    assign lead_o  = tick_o && !cnt_q[DIV_LOG2-1];
    assign trail_o = tick_o && cnt_q[DIV_LOG2-1];

    // Count while enabled; restart from zero when idle or when the parent changes phase.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en_i || clr_i) begin
            cnt_d = '0;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_mstr_gen2.sv
// SPI master: one DATA_W-bit word per request, all four modes, NUM_SS selects,
// optional SS hold between words for bursts to the same slave.
module spi_mstr_gen2
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DIV_LOG2 = 5,
    parameter int unsigned NUM_SS   = 2,
    localparam int unsigned SEL_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrt,
    input  logic [DATA_W-1:0] cmd,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic [1:0]        mode,
    input  logic              hold_ss,
    input  logic              MISO,
    output logic              SCLK,
    output logic              MOSI,
    output logic [NUM_SS-1:0] SS_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned       EDGE_W    = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    spi_state_t          state_q;
    logic [DATA_W-1:0]   sr_q;
    logic [DATA_W-1:0]   rd_q;
    logic [SEL_W-1:0]    sel_q;
    spi_mode_t           mode_q;
    logic                hold_q;
    logic                sclk_q;
    logic [NUM_SS-1:0]   ss_n_q;
    logic                busy_q;
    logic                done_q;
    logic                gap_q;   // one-cycle deselect before switching slaves out of HOLD
    logic                samp_q;
    logic [EDGE_W-1:0]   edge_cnt_q;

    logic wrt_ok;
    logic div_en;
    logic div_clr;
    logic tick;
    logic lead;
    logic trail;
    logic last_edge;

    // Active-low select pattern with only the addressed slave low.
    function automatic logic [NUM_SS-1:0] ss_mask(input logic [SEL_W-1:0] s);
        logic [NUM_SS-1:0] m;
        for (int unsigned i = 0; i < NUM_SS; i++) begin
            m[i] = (32'(s) != i);
        end
        return m;
    endfunction

    assign wrt_ok    = wrt && (32'(ss_sel) < NUM_SS);
    assign last_edge = (edge_cnt_q == LAST_EDGE);

    assign div_en  = ((state_q == StFront) && !gap_q) || (state_q == StShift) ||
                     (state_q == StBack);
    // SHIFT wraps naturally every period; FRONT/BACK end on a half period and must restart.
    assign div_clr = tick && (state_q != StShift);

    spi_sclk_div #(
        .DIV_LOG2 (DIV_LOG2)
    ) u_div (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (div_en),
        .clr_i   (div_clr),
        .tick_o  (tick),
        .lead_o  (lead),
        .trail_o (trail)
    );

    // Transfer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sr_q       <= '0;
            rd_q       <= '0;
            sel_q      <= '0;
            mode_q     <= MODE0;
            hold_q     <= 1'b0;
            sclk_q     <= 1'b0;
            ss_n_q     <= '1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            gap_q      <= 1'b0;
            samp_q     <= 1'b0;
            edge_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (wrt_ok) begin
                        state_q <= StFront;
                        sr_q    <= cmd;
                        sel_q   <= ss_sel;
                        mode_q  <= spi_mode_t'(mode);
                        hold_q  <= hold_ss;
                        sclk_q  <= mode[1];
                        ss_n_q  <= ss_mask(ss_sel);
                        busy_q  <= 1'b1;
                    end
                end
                StFront: begin
                    if (gap_q) begin
                        gap_q  <= 1'b0;
                        ss_n_q <= ss_mask(sel_q);
                    end else if (tick) begin
                        state_q    <= StShift;
                        edge_cnt_q <= '0;
                    end
                end
                StShift: begin
                    if (tick) begin
                        sclk_q     <= ~sclk_q;
                        edge_cnt_q <= edge_cnt_q + 1'b1;
                        if (lead) begin
                            if (!mode_q.cpha) begin
                                samp_q <= MISO;
                            end else if (edge_cnt_q != '0) begin
                                // First leading edge only launches the MSB already on MOSI.
                                sr_q <= {sr_q[DATA_W-2:0], samp_q};
                            end
                        end else if (trail) begin
                            if (!mode_q.cpha) begin
                                sr_q <= {sr_q[DATA_W-2:0], samp_q};
                            end else begin
                                samp_q <= MISO;
                                // No leading edge follows the last sample, so fold it in now.
                                if (last_edge) begin
                                    sr_q <= {sr_q[DATA_W-2:0], MISO};
                                end
                            end
                        end
                        if (last_edge) begin
                            state_q <= StBack;
                        end
                    end
                end
                StBack: begin
                    sclk_q <= mode_q.cpol;
                    if (tick) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        rd_q   <= sr_q;
                        if (hold_q) begin
                            state_q <= StHold;
                        end else begin
                            state_q <= StIdle;
                            ss_n_q  <= '1;
                        end
                    end
                end
                StHold: begin
                    if (wrt_ok) begin
                        sr_q   <= cmd;
                        sel_q  <= ss_sel;
                        mode_q <= spi_mode_t'(mode);
                        hold_q <= hold_ss;
                        sclk_q <= mode[1];
                        busy_q <= 1'b1;
                        if (ss_sel == sel_q) begin
                            state_q    <= StShift;
                            edge_cnt_q <= '0;
                        end else begin
                            state_q <= StFront;
                            ss_n_q  <= '1;
                            gap_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign SCLK    = sclk_q;
    assign MOSI    = sr_q[DATA_W-1];
    assign SS_n    = ss_n_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_data = rd_q;

endmodule

// File: tb/tb_spi_mstr_gen2.sv
// Self-checking bench for spi_mstr_gen2: table of loopback words plus hand-written
// sequences for slave model, bursts, slave switch, ignored requests and reset abort.
module tb_spi_mstr_gen2;
    import spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrt = 1'b0;
    logic [15:0] cmd = '0;
    logic        ss_sel = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        hold_ss = 1'b0;
    logic        miso;
    logic        sclk, mosi, busy, done;
    logic [1:0]  ss_n;
    logic [15:0] rd_data;

    logic        wrt8 = 1'b0;
    logic [7:0]  cmd8 = '0;
    logic [1:0]  sel8 = '0;
    logic        sclk8, mosi8, busy8, done8;
    logic [3:0]  ss_n8;
    logic [7:0]  rd8;

    logic        slave_en = 1'b0;
    logic        slv_miso = 1'b0;
    logic [15:0] slv_sr = '0;
    logic        sclk_prev = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  exp8_q[$];

    typedef struct {
        logic [15:0] cmd;
        logic [1:0]  mode;
        logic        sel;
        logic [1:0]  exp_ss;
        logic [15:0] exp_rd;
        int          exp_lat;
    } vec_t;

    always #5 clk = ~clk;

    assign miso = slave_en ? slv_miso : mosi;

    spi_mstr_gen2 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .cmd     (cmd),
        .ss_sel  (ss_sel),
        .mode    (mode),
        .hold_ss (hold_ss),
        .MISO    (miso),
        .SCLK    (sclk),
        .MOSI    (mosi),
        .SS_n    (ss_n),
        .busy    (busy),
        .done    (done),
        .rd_data (rd_data)
    );

    spi_mstr_gen2 #(
        .DATA_W   (8),
        .DIV_LOG2 (2),
        .NUM_SS   (4)
    ) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt8),
        .cmd     (cmd8),
        .ss_sel  (sel8),
        .mode    (2'b00),
        .hold_ss (1'b0),
        .MISO    (mosi8),
        .SCLK    (sclk8),
        .MOSI    (mosi8),
        .SS_n    (ss_n8),
        .busy    (busy8),
        .done    (done8),
        .rd_data (rd8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Mode-3 style slave: presents the next bit after each falling SCLK while enabled.
    always @(posedge clk) begin
        sclk_prev <= sclk;
        if (!slave_en) begin
            slv_sr   <= 16'h3C96;
            slv_miso <= 1'b0;
        end else if (sclk_prev && !sclk) begin
            slv_miso <= slv_sr[15];
            slv_sr   <= {slv_sr[14:0], 1'b0};
        end
    end

    // Scoreboards: pop the expected word whenever a done pulse appears.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_done", 32'd1, 32'd0);
            else check("rd_data", rd_data, exp_q.pop_front());
        end
        if (done8 === 1'b1) begin
            if (exp8_q.size() == 0) check("spurious_done8", 32'd1, 32'd0);
            else check("rd_data8", rd8, exp8_q.pop_front());
        end
    end

    task automatic start_word(input logic [15:0] c, input logic [1:0] m, input logic s,
                              input logic h, input bit push, input logic [15:0] exp_rd);
        @(negedge clk);
        cmd = c; mode = m; ss_sel = s; hold_ss = h; wrt = 1'b1;
        if (push) exp_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        wrt = 1'b0;
        check("busy_after_wrt", busy, 1);
    endtask

    task automatic wait_done(input string name, input int exp_lat, input logic [1:0] exp_ss,
                             input int lat0);
        int lat;
        bit ss_ok;
        lat = lat0;
        ss_ok = 1'b1;
        while (done !== 1'b1 && lat < 3000) begin
            if (ss_n !== exp_ss) ss_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_ss_n"}, 32'(ss_ok), 32'd1);
    endtask

    initial begin
        vec_t vecs[5];
        int   lat, rises, n_done;
        logic prev;
        bit   ok;

        vecs[0] = '{16'hA5C3, MODE0, 1'b1, 2'b01, 16'hA5C3, 544};
        vecs[1] = '{16'h0001, MODE1, 1'b0, 2'b10, 16'h0001, 544};
        vecs[2] = '{16'h8000, MODE2, 1'b1, 2'b01, 16'h8000, 544};
        vecs[3] = '{16'hFFFF, MODE3, 1'b0, 2'b10, 16'hFFFF, 544};
        vecs[4] = '{16'h5A3C, MODE1, 1'b1, 2'b01, 16'h5A3C, 544};

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_n", ss_n, 2'b11);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_ss_n8", ss_n8, 4'b1111);
        @(negedge clk);
        rst_n = 1'b1;

        // Loopback table across all four modes.
        for (int i = 0; i < 5; i++) begin
            start_word(vecs[i].cmd, vecs[i].mode, vecs[i].sel, 1'b0, 1'b1, vecs[i].exp_rd);
            wait_done($sformatf("vec%0d", i), vecs[i].exp_lat, vecs[i].exp_ss, 0);
            check($sformatf("vec%0d_busy_at_done", i), busy, 0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_ss_idle", i), ss_n, 2'b11);
        end

        // Mode 3 against a slave model returning 16'h3C96.
        slave_en = 1'b1;
        repeat (2) @(posedge clk);
        start_word(16'h0000, MODE3, 1'b1, 1'b0, 1'b1, 16'h3C96);
        check("m3_sclk_before", sclk, 1);
        lat = 0; rises = 0; prev = sclk;
        while (done !== 1'b1 && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
            if (!prev && sclk) rises++;
            prev = sclk;
        end
        check("m3_latency", lat, 544);
        check("m3_rises", rises, 16);
        check("m3_sclk_after", sclk, 1);
        slave_en = 1'b0;

        // Burst to one slave: SS held low, second word skips FRONT.
        start_word(16'h1234, MODE0, 1'b1, 1'b1, 1'b1, 16'h1234);
        wait_done("burst1", 544, 2'b01, 0);
        @(posedge clk);
        #1;
        check("hold_ss_n", ss_n, 2'b01);
        check("hold_busy", busy, 0);
        start_word(16'h5678, MODE0, 1'b1, 1'b0, 1'b1, 16'h5678);
        wait_done("burst2", 528, 2'b01, 0);
        @(posedge clk);
        #1;
        check("burst_end_ss_n", ss_n, 2'b11);

        // Held burst then switch slave: one deselected cycle, then FRONT on the new slave.
        start_word(16'h0F0F, MODE0, 1'b1, 1'b1, 1'b1, 16'h0F0F);
        wait_done("sw1", 544, 2'b01, 0);
        start_word(16'hF0F0, MODE0, 1'b0, 1'b0, 1'b1, 16'hF0F0);
        check("sw_gap_ss_n", ss_n, 2'b11);
        @(posedge clk);
        #1;
        wait_done("sw2", 545, 2'b10, 1);

        // Request while busy is ignored.
        start_word(16'h1357, MODE0, 1'b1, 1'b0, 1'b1, 16'h1357);
        repeat (150) @(posedge clk);
        @(negedge clk);
        cmd = 16'hFFFF; ss_sel = 1'b0; hold_ss = 1'b1; wrt = 1'b1;
        @(posedge clk);
        #1;
        wrt = 1'b0;
        wait_done("ign", 544, 2'b01, 151);
        n_done = 0;
        repeat (600) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) n_done++;
        end
        check("ign_extra_done", n_done, 0);
        check("ign_rd_kept", rd_data, 16'h1357);

        // Request held across the done edge is taken one cycle later.
        start_word(16'h2468, MODE0, 1'b0, 1'b0, 1'b1, 16'h2468);
        repeat (543) @(posedge clk);
        @(negedge clk);
        cmd = 16'h1111; mode = MODE0; ss_sel = 1'b0; hold_ss = 1'b0; wrt = 1'b1;
        @(posedge clk);
        #1;
        check("dc_done", done, 1);
        check("dc_busy_low", busy, 0);
        exp_q.push_back(16'h1111);
        @(posedge clk);
        #1;
        wrt = 1'b0;
        check("dc_busy_taken", busy, 1);
        wait_done("dc2", 544, 2'b10, 0);

        // Reset at cycle 200 aborts without a done pulse.
        start_word(16'hBEEF, MODE1, 1'b1, 1'b0, 1'b0, 16'h0000);
        repeat (199) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ss_n", ss_n, 2'b11);
        check("abort_sclk", sclk, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        repeat (600) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) n_done++;
        end
        check("abort_no_done", n_done, 0);

        // Narrow instance: 8-bit words, H=2, four selects.
        for (int i = 0; i < 2; i++) begin
            logic [7:0] c8;
            logic [1:0] s8;
            logic [3:0] e8;
            c8 = (i == 0) ? 8'h81 : 8'h3C;
            s8 = (i == 0) ? 2'd3 : 2'd0;
            e8 = (i == 0) ? 4'b0111 : 4'b1110;
            @(negedge clk);
            cmd8 = c8; sel8 = s8; wrt8 = 1'b1;
            exp8_q.push_back(c8);
            @(posedge clk);
            #1;
            wrt8 = 1'b0;
            lat = 0; ok = 1'b1;
            while (done8 !== 1'b1 && lat < 200) begin
                if (ss_n8 !== e8) ok = 1'b0;
                @(posedge clk);
                #1;
                lat++;
            end
            check($sformatf("n8_%0d_latency", i), lat, 36);
            check($sformatf("n8_%0d_ss_n", i), 32'(ok), 32'd1);
            @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        #2;
        check("sb_empty", exp_q.size(), 0);
        check("sb8_empty", exp8_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
